// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per cycle, sign fix-up, then a held result for write-back.
module muldiv_unit #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [2:0]           funct3,
   input  logic [4:0]           rd_addr,
   input  logic [WORD_SIZE-1:0] operand_a,
   input  logic [WORD_SIZE-1:0] operand_b,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic [WORD_SIZE-1:0] result_data,
   output logic [4:0]           result_rd
);

   localparam int CW = $clog2(WORD_SIZE);
   localparam logic [WORD_SIZE-1:0] MIN_INT = {1'b1, {(WORD_SIZE-1){1'b0}}};
   localparam logic [CW-1:0] LAST_STEP = CW'(WORD_SIZE - 1);

   typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

   state_t                   state, next_state;
   logic [2:0]               op_funct3;
   logic                     sign_a, sign_b;
   logic [WORD_SIZE-1:0]     opnd;       // divisor magnitude, or multiplicand magnitude
   logic [2*WORD_SIZE-1:0]   acc;        // {remainder, quotient} or running product
   logic [CW-1:0]            counter;

   logic                     accept, is_div_in, fast_path;
   logic                     signed_a, signed_b, neg_a_in, neg_b_in;
   logic [WORD_SIZE-1:0]     mag_a_in, mag_b_in, fast_data;
   logic [2*WORD_SIZE-1:0]   step_next;
   logic [WORD_SIZE-1:0]     fix_data;

   assign start_ready  = (state == IDLE);
   assign result_valid = (state == DONE);
   assign accept       = start_valid && start_ready && !flush;
   assign is_div_in    = funct3[2];

   // Decode the incoming request: signedness, magnitudes and the div0/overflow shortcut.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      signed_a  = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
      signed_b  = is_div_in ? ~funct3[0] : ~funct3[1];
      neg_a_in  = signed_a && operand_a[WORD_SIZE-1];
      neg_b_in  = signed_b && operand_b[WORD_SIZE-1];
      mag_a_in  = neg_a_in ? -operand_a : operand_a;
      mag_b_in  = neg_b_in ? -operand_b : operand_b;
      fast_path = 1'b0;
      fast_data = '0;
      if (is_div_in && operand_b == '0) begin
         fast_path = 1'b1;
         fast_data = funct3[1] ? operand_a : '1;
      end else if (is_div_in && !funct3[0] && operand_a == MIN_INT && operand_b == '1) begin
         fast_path = 1'b1;
         fast_data = funct3[1] ? '0 : MIN_INT;
      end
   end

   // One iteration: shift-add multiply or restoring divide on the magnitudes.
   always_comb begin
      logic [WORD_SIZE:0] mul_sum;
      logic [WORD_SIZE:0] shifted;
      mul_sum   = {1'b0, acc[2*WORD_SIZE-1:WORD_SIZE]} + {1'b0, (acc[0] ? opnd : '0)};
      shifted   = {acc[2*WORD_SIZE-1:WORD_SIZE], acc[WORD_SIZE-1]};
      step_next = {mul_sum, acc[WORD_SIZE-1:1]};
      if (op_funct3[2]) begin
         if (shifted >= {1'b0, opnd})
            step_next = {WORD_SIZE'(shifted - {1'b0, opnd}), acc[WORD_SIZE-2:0], 1'b1};
         else
            step_next = {shifted[WORD_SIZE-1:0], acc[WORD_SIZE-2:0], 1'b0};
      end
   end

   // Sign correction and word selection once the iterations are complete.
   always_comb begin
      logic [2*WORD_SIZE-1:0] prod_fix;
      logic [WORD_SIZE-1:0]   quo_fix, rem_fix;
      prod_fix = (sign_a ^ sign_b) ? -acc : acc;
      quo_fix  = (sign_a ^ sign_b) ? -acc[WORD_SIZE-1:0] : acc[WORD_SIZE-1:0];
      rem_fix  = sign_a ? -acc[2*WORD_SIZE-1:WORD_SIZE] : acc[2*WORD_SIZE-1:WORD_SIZE];
      if (op_funct3[2])
         fix_data = op_funct3[1] ? rem_fix : quo_fix;
      else if (op_funct3[1:0] == 2'b00)
         fix_data = prod_fix[WORD_SIZE-1:0];
      else
         fix_data = prod_fix[2*WORD_SIZE-1:WORD_SIZE];
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = fast_path ? DONE : BUSY;
         BUSY:    if (counter == LAST_STEP) next_state = FIXUP;
         FIXUP:   next_state = DONE;
         DONE:    if (result_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: registered state uses non-blocking assignment so every flop sees pre-edge values.
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Datapath registers: capture at accept, iterate in BUSY, publish in FIXUP.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         op_funct3   <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         opnd        <= '0;
         acc         <= '0;
         counter     <= '0;
         result_data <= '0;
         result_rd   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_funct3 <= funct3;
               result_rd <= rd_addr;
               sign_a    <= neg_a_in;
               sign_b    <= neg_b_in;
               counter   <= '0;
               if (fast_path) result_data <= fast_data;
               if (is_div_in) begin
                  acc  <= {{WORD_SIZE{1'b0}}, mag_a_in};
                  opnd <= mag_b_in;
               end else begin
                  acc  <= {{WORD_SIZE{1'b0}}, mag_b_in};
                  opnd <= mag_a_in;
               end
            end
            BUSY: begin
               acc     <= step_next;
               counter <= counter + CW'(1);
            end
            FIXUP:   result_data <= fix_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed expectations.
module tb_muldiv_unit;

   localparam int WS = 32;
   localparam int NORMAL_LAT = WS + 2;   // cycles from accept cycle to first valid cycle
   localparam int FAST_LAT   = 1;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          start_valid = 1'b0;
   logic          start_ready;
   logic [2:0]    funct3 = '0;
   logic [4:0]    rd_addr = '0;
   logic [WS-1:0] operand_a = '0;
   logic [WS-1:0] operand_b = '0;
   logic          result_valid;
   logic          result_ready = 1'b0;
   logic [WS-1:0] result_data;
   logic [4:0]    result_rd;

   int checks = 0;
   int errors = 0;
   bit ready_in_flight;
   bit valid_seen;

   muldiv_unit #(.WORD_SIZE(WS)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .start_valid(start_valid), .start_ready(start_ready),
      .funct3(funct3), .rd_addr(rd_addr),
      .operand_a(operand_a), .operand_b(operand_b),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_data(result_data), .result_rd(result_rd)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present a request for one cycle; afterwards scramble the inputs.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      @(negedge clock);
      start_valid = 1'b1;
      funct3 = f; operand_a = a; operand_b = b; rd_addr = rd;
      @(posedge clock); #1;
      start_valid = 1'b0;
      funct3 = 3'($urandom()); operand_a = $urandom(); operand_b = $urandom();
      rd_addr = 5'($urandom());
   endtask

   // Cycles from the accept cycle to the first cycle with result_valid high (bounded).
   task automatic wait_result(output int lat);
      lat = 1;
      ready_in_flight = 1'b0;
      while (!result_valid && lat < 200) begin
         if (start_ready) ready_in_flight = 1'b1;
         @(posedge clock); #1;
         lat++;
      end
   endtask

   task automatic retire(input string tag);
      result_ready = 1'b1;
      @(posedge clock); #1;
      result_ready = 1'b0;
      check({tag, "_retire"}, {31'b0, result_valid, 31'b0, start_ready}, {31'b0, 1'b0, 31'b0, 1'b1});
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_data, input int exp_lat);
      int lat;
      issue(f, a, b, rd);
      wait_result(lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_data"}, result_data, exp_data);
      check({tag, "_rd"}, {27'b0, result_rd}, {27'b0, rd});
      retire(tag);
   endtask

   // Start an op, abort it at BUSY cycle 15 with flush or reset, then watch valid stay low.
   task automatic abort_test(input string tag, input bit use_reset);
      issue(3'b000, 32'h1234_5678, 32'h0000_0009, 5'd7);
      repeat (14) @(posedge clock);
      @(negedge clock);
      if (use_reset) reset_n = 1'b0; else flush = 1'b1;
      @(posedge clock); #1;
      reset_n = 1'b1; flush = 1'b0;
      check({tag, "_ready"}, {31'b0, start_ready}, 32'd1);
      valid_seen = 1'b0;
      repeat (40) begin
         if (result_valid) valid_seen = 1'b1;
         @(posedge clock); #1;
      end
      check({tag, "_no_valid"}, {31'b0, valid_seen}, 32'd0);
      if (use_reset) check({tag, "_rd_cleared"}, {27'b0, result_rd}, 32'd0);
      run_op({tag, "_divu"}, 3'b101, 32'd9, 32'd3, 5'd11, 32'd3, NORMAL_LAT);
   endtask

   initial begin
      int lat;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      check("reset_ready", {31'b0, start_ready}, 32'd1);
      check("reset_valid", {31'b0, result_valid}, 32'd0);
      check("reset_data", result_data, 32'd0);
      check("reset_rd", {27'b0, result_rd}, 32'd0);

      // MUL 7 * -3, with start_ready watched through the op
      issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
      wait_result(lat);
      check("mul_lat", lat, NORMAL_LAT);
      check("mul_ready_low", {31'b0, ready_in_flight}, 32'd0);
      check("mul_data", result_data, 32'hFFFF_FFEB);
      check("mul_rd", {27'b0, result_rd}, 32'd5);
      retire("mul");

      run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, NORMAL_LAT);
      run_op("mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, NORMAL_LAT);
      run_op("mulhsu_neg", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, NORMAL_LAT);
      run_op("mul_big",    3'b000, 32'h1234_5678, 32'h0000_0009, 5'd4,  32'hA3D7_0A38, NORMAL_LAT);
      run_op("div_neg",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, NORMAL_LAT);
      run_op("rem_neg",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, NORMAL_LAT);
      run_op("div_negb",   3'b100, 32'd7,         32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFD, NORMAL_LAT);
      run_op("rem_negb",   3'b110, 32'd7,         32'hFFFF_FFFE, 5'd9,  32'h0000_0001, NORMAL_LAT);
      run_op("divu",       3'b101, 32'd100,       32'd7,         5'd10, 32'd14,        NORMAL_LAT);
      run_op("remu",       3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         NORMAL_LAT);

      // Fast path: divide by zero and signed overflow
      run_op("div_zero",   3'b100, 32'h0000_1234, 32'd0,         5'd13, 32'hFFFF_FFFF, FAST_LAT);
      run_op("rem_zero",   3'b110, 32'h0000_1234, 32'd0,         5'd14, 32'h0000_1234, FAST_LAT);
      run_op("divu_zero",  3'b101, 32'h8765_4321, 32'd0,         5'd15, 32'hFFFF_FFFF, FAST_LAT);
      run_op("remu_zero",  3'b111, 32'h8765_4321, 32'd0,         5'd16, 32'h8765_4321, FAST_LAT);
      run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, FAST_LAT);
      run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, FAST_LAT);

      // Back-pressure: hold result_ready low for 10 cycles in DONE
      issue(3'b101, 32'd100, 32'd7, 5'd21);
      wait_result(lat);
      check("stall_lat", lat, NORMAL_LAT);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #1;
         check("stall_data", result_data, 32'd14);
         check("stall_rd", {27'b0, result_rd}, 32'd21);
         check("stall_flags", {30'b0, result_valid, start_ready}, 32'b10);
      end
      retire("stall");

      // A start request coincident with flush in IDLE is ignored
      @(negedge clock);
      start_valid = 1'b1; flush = 1'b1; funct3 = 3'b101; operand_a = 32'd9; operand_b = 32'd3;
      @(posedge clock); #1;
      start_valid = 1'b0; flush = 1'b0;
      check("flush_ignores_start", {31'b0, start_ready}, 32'd1);

      abort_test("flush_busy", 1'b0);
      abort_test("reset_busy", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
